// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exec_sequencer
// Brief    : Multi-cycle execution controller for the picoMIPS core. Passes
//            single-cycle instructions straight through, stalls the PC for a
//            serial signed shift-add multiply and for a switch-input
//            valid/release handshake, and drives the writeback source select.
// Revision : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_PCincr,
    input  logic             dec_PCabsbranch,
    input  logic             dec_PCrelbranch,
    input  logic             dec_w,
    input  logic             is_mul,
    input  logic             is_in,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             PCincr,
    output logic             PCabsbranch,
    output logic             PCrelbranch,
    output logic             w,
    output logic [1:0]       wb_sel,
    output logic [WIDTH-1:0] mul_result,
    output logic             busy,
    output logic             in_ack
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_WB_ALU = 2'b00;
    localparam logic [1:0] c_WB_MUL = 2'b01;
    localparam logic [1:0] c_WB_IN  = 2'b10;

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_MUL     = 3'd1,
        S_DONE    = 3'd2,
        S_WAITIN  = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_sign;
    logic [WIDTH-1:0]     r_mul_result;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod;

    // Operand magnitudes (the most-negative value maps to its unsigned
    // magnitude), the next partial sum and the sign-corrected full product.
    always_comb begin
        w_abs_a    = op_a[WIDTH-1] ? (-op_a) : op_a;
        w_abs_b    = op_b[WIDTH-1] ? (-op_b) : op_b;
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_prod     = r_sign ? (-w_acc_next) : w_acc_next;
    end

    // Sequencer state, multiply datapath and the held multiply result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_RUN;
            r_cnt        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_sign       <= 1'b0;
            r_mul_result <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (is_mul) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_sign   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_MUL;
                    end else if (is_in) begin
                        r_state  <= S_WAITIN;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        // Truncating slice of the exact product; wraps on overflow.
                        r_mul_result <= WIDTH'(w_prod >> FRAC);
                        r_state      <= S_DONE;
                    end
                end
                S_DONE:    r_state <= S_RUN;
                S_WAITIN:  if (in_valid)  r_state <= S_RELEASE;
                S_RELEASE: if (!in_valid) r_state <= S_RUN;
                default:   r_state <= S_RUN;
            endcase
        end
    end

    // Gated PC/write controls, writeback select and handshake outputs.
    always_comb begin
        PCincr      = 1'b0;
        PCabsbranch = 1'b0;
        PCrelbranch = 1'b0;
        w           = 1'b0;
        wb_sel      = c_WB_ALU;
        busy        = 1'b0;
        in_ack      = 1'b0;
        if (!reset) begin
            case (r_state)
                S_RUN: begin
                    if (is_mul || is_in) begin
                        busy = 1'b1;
                    end else begin
                        PCincr      = dec_PCincr;
                        PCabsbranch = dec_PCabsbranch;
                        PCrelbranch = dec_PCrelbranch;
                        w           = dec_w;
                    end
                end
                S_MUL: busy = 1'b1;
                S_DONE: begin
                    w      = 1'b1;
                    PCincr = 1'b1;
                    wb_sel = c_WB_MUL;
                end
                S_WAITIN: begin
                    if (in_valid) begin
                        w      = 1'b1;
                        PCincr = 1'b1;
                        wb_sel = c_WB_IN;
                        in_ack = 1'b1;
                    end else begin
                        busy = 1'b1;
                    end
                end
                S_RELEASE: busy = 1'b1;
                default: busy = 1'b0;
            endcase
        end
    end

    assign mul_result = reset ? '0 : r_mul_result;

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle execution controller for the picoMIPS core, placed between the instruction decoder and the PC/register file. Single-cycle instructions pass through unchanged. The sequencer stalls the PC for two cases:
- a serial signed shift-add multiply, used by the matrix kernels;
- a switch-input instruction, using a valid/release handshake.

It also drives the writeback source select.

Parameters:
WIDTH, 8, datapath/operand width in bits
FRAC, 0, fractional bits; the result is product[FRAC+WIDTH-1:FRAC], legal range 0..WIDTH

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous active-high reset
dec_PCincr  in  1  decoder PC increment request
dec_PCabsbranch  in  1  decoder absolute branch request
dec_PCrelbranch  in  1  decoder relative branch request
dec_w  in  1  decoder register write request
is_mul  in  1  current instruction is MUL (multi-cycle)
is_in  in  1  current instruction reads switch input
in_valid  in  1  external input-ready level (switch), already synchronised
op_a  in  WIDTH  multiplicand (Rd value), signed
op_b  in  WIDTH  multiplier (Rs/imm value), signed
PCincr  out  1  gated PC increment
PCabsbranch  out  1  gated absolute branch
PCrelbranch  out  1  gated relative branch
w  out  1  gated register write enable
wb_sel  out  2  writeback source: 00 ALU, 01 multiplier, 10 input port
mul_result  out  WIDTH  truncated signed product, registered
busy  out  1  high while the instruction is stalled
in_ack  out  1  one-cycle pulse when input data is written

Behaviour:
- Reset: while reset is high, state=RUN, counter=0, mul_result=0, and all outputs are forced to 0 (including wb_sel=00). Reset mid-MUL or mid-handshake aborts with no write and no PC change.
- States: RUN, MUL, DONE, WAITIN, RELEASE.
- RUN, is_mul=0 and is_in=0:
  - PC*/w outputs equal the dec_* inputs, combinationally;
  - wb_sel=00, busy=0.
- RUN, is_mul=1:
  - load cycle: capture |op_a| and |op_b| and the sign (op_a[msb]^op_b[msb]); clear the 2*WIDTH accumulator; counter=0;
  - outputs PC*=0, w=0, busy=1; next state MUL.
- MUL:
  - one shift-add iteration per cycle, over multiplier bits LSB-first;
  - busy=1 and all PC*/w outputs are 0;
  - after WIDTH iterations (counter==WIDTH-1), apply the sign correction (two's-complement negate if the sign is 1), register mul_result, and go to DONE.
- DONE (one cycle):
  - w=1, PCincr=1, branches=0, wb_sel=01, busy=0; next state RUN.
  - MUL total latency is WIDTH+2 cycles from instruction present to PC advance (10 for WIDTH=8).
- Operand capture: op_a and op_b are sampled only in the load cycle; later changes are ignored.
- Arithmetic: the full 2*WIDTH signed product is exact. The result is the truncated slice, with no saturation or rounding. The most-negative times most-negative overflow wraps per the slice.
- RUN, is_in=1: go to WAITIN.
- WAITIN:
  - busy=1 and PC*/w outputs are 0 while in_valid=0;
  - in the first cycle with in_valid=1: w=1, PCincr=1, wb_sel=10, in_ack=1, busy=0; next state RELEASE.
  - If in_valid is already high on entry, the write occurs in the first WAITIN cycle (latency 2).
- RELEASE:
  - stalls the following instruction (PC*/w=0, busy=1) until in_valid=0, then returns to RUN;
  - a held switch never double-reads.
- Priority: is_mul and is_in are never both set. If they are, is_mul wins.
- dec_* inputs are ignored outside RUN.
- mul_result holds its value until the next MUL completes.

Test Plan:
- WIDTH=8, FRAC=0, ADD in RUN with dec_PCincr=1, dec_w=1 -> PCincr=1, w=1, wb_sel=00, busy=0 in the same cycle.
- MUL op_a=8'hFD (-3), op_b=8'h05 -> busy for 9 cycles, then on cycle 10: w=1, PCincr=1, wb_sel=01, mul_result=8'hF1. Changing op_a during MUL has no effect.
- FRAC=7, op_a=op_b=8'h80 (-128) -> product 16'h4000, mul_result=8'h80. With FRAC=0 -> 8'h00.
- IN with in_valid=0 for 5 cycles, then held high for 4 cycles, then low -> exactly one in_ack/w pulse with wb_sel=10. busy stays high through RELEASE and drops the cycle after in_valid falls.
- Assert reset in MUL iteration 4 -> next cycle state=RUN, mul_result=0, w=0, PCincr=0. A subsequent MUL 7*6 returns 8'h2A.
- Relative branch in RUN (dec_PCrelbranch=1, dec_PCincr=0) -> passed through. The same inputs presented during MUL produce PCrelbranch=0.
